parking_gate_decoder: RTL and testbench
=======================================

Name: parking_gate_decoder

Overview:
Upstream stage of the parking-lot occupancy counter. Takes two raw optical beam sensors at the gate and synchronises and debounces them. A direction FSM then decodes complete vehicle passages into single-cycle enter and exit pulses. count_e drives the counter's count enable directly, one pulse per completed entry. Aborted, reversed or illegal sensor sequences never produce a pulse.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required before a filtered sensor changes (legal range 1..255)
DB_W, 8, width of each debounce counter; must hold DEBOUNCE_CYCLES-1

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
sensor_a  input  1  raw outer beam, 1 = beam blocked, asynchronous to clock
sensor_b  input  1  raw inner beam, 1 = beam blocked, asynchronous to clock
car_enter  output  1  one-cycle pulse: completed entry (a, ab, b, clear)
car_exit  output  1  one-cycle pulse: completed exit (b, ab, a, clear)
count_e  output  1  equals car_enter; feeds the occupancy counter's count_e
seq_error  output  1  one-cycle pulse on entry to ERROR state
lane_busy  output  1  1 while FSM is not in IDLE

Behaviour:
- One clock, synchronous active-high reset. On reset: sync flops, filtered a/b and debounce counters cleared to 0, FSM = IDLE, all outputs 0.
- Synchroniser: two flops per sensor (s1, s2).
- Debounce, per sensor:
  - If s2 == filtered, counter is cleared to 0.
  - If s2 != filtered and counter == DEBOUNCE_CYCLES-1, filtered <= s2 and counter is cleared.
  - Otherwise counter increments.
  - Any bounce back to the filtered value restarts the count.
- Timing: raw change first sampled at edge 0, filtered value changes at edge DEBOUNCE_CYCLES+1. Outputs are registered and high for exactly one cycle, from edge DEBOUNCE_CYCLES+2 to DEBOUNCE_CYCLES+3.
- FSM input is the filtered pair ab. States: IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, ERROR. A pair not listed under a state holds that state.
  - IDLE: 10 -> IN1. 01 -> OUT1. 11 -> ERROR.
  - IN1: 11 -> IN2. 00 -> IDLE (abort, no pulse). 01 -> ERROR.
  - IN2: 01 -> IN3. 10 -> IN1 (backing out). 00 -> ERROR.
  - IN3: 00 -> IDLE and car_enter/count_e pulse. 11 -> IN2. 10 -> ERROR.
  - OUT1/OUT2/OUT3 mirror IN1/IN2/IN3 with a and b swapped. OUT3 -> IDLE on 00 produces a car_exit pulse.
  - ERROR: seq_error pulses on the transition into ERROR only. Stays in ERROR until ab = 00, then goes to IDLE with no pulse.
- Exclusivity: car_enter and car_exit are never high in the same cycle. count_e == car_enter in every cycle.
- lane_busy is registered and mirrors the current state (state != IDLE).
- Both sensors changing in the same cycle is handled purely by the resulting filtered pair per the table.
- Reset asserted mid-passage: FSM returns to IDLE and no pulse is produced. After reset deasserts, a vehicle still blocking the beam is decoded per the IDLE row.

Test Plan (DEBOUNCE_CYCLES=4):
1. Entry: raw ab 10, 11, 01, 00, each held 10 cycles -> exactly one car_enter and one count_e pulse, 6 cycles after the final 00 is first sampled. car_exit stays 0, lane_busy falls at the same edge.
2. Exit: raw ab 01, 11, 10, 00 -> one car_exit pulse; car_enter and count_e stay 0 throughout.
3. Bounce: sensor_a toggles 1/0/1/0 with 2-cycle pulses, then settles at 0 -> filtered a never changes, FSM stays IDLE, no outputs. A 4-cycle-stable 1 moves FSM to IN1.
4. Abort and reverse:
   - ab 10, 00 -> no pulse.
   - ab 10, 11, 10, 11, 01, 00 -> exactly one car_enter.
5. Illegal sequence: from IDLE, ab 10 then 01 -> seq_error high for 1 cycle, FSM in ERROR. Holding 01 gives no further pulses. 00 -> IDLE, and a following legal entry counts normally.
6. Reset mid-passage: reset high for 1 cycle while in IN2 -> all outputs 0 next cycle, state IDLE. Continuing the sequence 01, 00 yields no car_enter.

Source files
------------

// File: rtl/parking_gate_decoder.sv
// Gate sensor front end: synchronises and debounces the two beam sensors, then decodes
// complete vehicle passages into single-cycle enter/exit pulses for the occupancy counter.
module parking_gate_decoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DB_W            = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic sensor_a,
  input  logic sensor_b,
  output logic car_enter,
  output logic car_exit,
  output logic count_e,
  output logic seq_error,
  output logic lane_busy
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    IN1,
    IN2,
    IN3,
    OUT1,
    OUT2,
    OUT3,
    ERROR
  } state_t;

  logic            a_s1_q, a_s1_d, a_s2_q, a_s2_d;
  logic            b_s1_q, b_s1_d, b_s2_q, b_s2_d;
  logic            a_filt_q, a_filt_d, b_filt_q, b_filt_d;
  logic [DB_W-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;

  state_t          state_q, state_d;
  logic            car_enter_q, car_enter_d;
  logic            car_exit_q, car_exit_d;
  logic            seq_error_q, seq_error_d;
  logic            lane_busy_q, lane_busy_d;
  logic [1:0]      ab;

  always_comb begin
    a_s1_d = sensor_a;
    a_s2_d = a_s1_q;
    b_s1_d = sensor_b;
    b_s2_d = b_s1_q;
  end

  // A sensor only takes a new level after DEBOUNCE_CYCLES consecutive differing samples;
  // any sample equal to the current filtered level restarts the count.
  always_comb begin
    a_cnt_d  = a_cnt_q;
    a_filt_d = a_filt_q;
    if (a_s2_q == a_filt_q) begin
      a_cnt_d = '0;
    end else if (a_cnt_q == DB_LAST) begin
      a_filt_d = a_s2_q;
      a_cnt_d  = '0;
    end else begin
      a_cnt_d = a_cnt_q + DB_ONE;
    end
  end

  always_comb begin
    b_cnt_d  = b_cnt_q;
    b_filt_d = b_filt_q;
    if (b_s2_q == b_filt_q) begin
      b_cnt_d = '0;
    end else if (b_cnt_q == DB_LAST) begin
      b_filt_d = b_s2_q;
      b_cnt_d  = '0;
    end else begin
      b_cnt_d = b_cnt_q + DB_ONE;
    end
  end

  // Direction decode on the filtered pair; pairs not listed for a state hold it.
  always_comb begin
    ab          = {a_filt_q, b_filt_q};
    state_d     = state_q;
    car_enter_d = 1'b0;
    car_exit_d  = 1'b0;
    case (state_q)
      IDLE: begin
        case (ab)
          2'b10:   state_d = IN1;
          2'b01:   state_d = OUT1;
          2'b11:   state_d = ERROR;
          default: state_d = IDLE;
        endcase
      end
      IN1: begin
        case (ab)
          2'b11:   state_d = IN2;
          2'b00:   state_d = IDLE;
          2'b01:   state_d = ERROR;
          default: state_d = IN1;
        endcase
      end
      IN2: begin
        case (ab)
          2'b01:   state_d = IN3;
          2'b10:   state_d = IN1;
          2'b00:   state_d = ERROR;
          default: state_d = IN2;
        endcase
      end
      IN3: begin
        case (ab)
          2'b00: begin
            state_d     = IDLE;
            car_enter_d = 1'b1;
          end
          2'b11:   state_d = IN2;
          2'b10:   state_d = ERROR;
          default: state_d = IN3;
        endcase
      end
      OUT1: begin
        case (ab)
          2'b11:   state_d = OUT2;
          2'b00:   state_d = IDLE;
          2'b10:   state_d = ERROR;
          default: state_d = OUT1;
        endcase
      end
      OUT2: begin
        case (ab)
          2'b10:   state_d = OUT3;
          2'b01:   state_d = OUT1;
          2'b00:   state_d = ERROR;
          default: state_d = OUT2;
        endcase
      end
      OUT3: begin
        case (ab)
          2'b00: begin
            state_d    = IDLE;
            car_exit_d = 1'b1;
          end
          2'b11:   state_d = OUT2;
          2'b01:   state_d = ERROR;
          default: state_d = OUT3;
        endcase
      end
      ERROR: begin
        if (ab == 2'b00) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    seq_error_d = (state_d == ERROR) && (state_q != ERROR);
    lane_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_s1_q      <= 1'b0;
      a_s2_q      <= 1'b0;
      b_s1_q      <= 1'b0;
      b_s2_q      <= 1'b0;
      a_filt_q    <= 1'b0;
      b_filt_q    <= 1'b0;
      a_cnt_q     <= '0;
      b_cnt_q     <= '0;
      state_q     <= IDLE;
      car_enter_q <= 1'b0;
      car_exit_q  <= 1'b0;
      seq_error_q <= 1'b0;
      lane_busy_q <= 1'b0;
    end else begin
      a_s1_q      <= a_s1_d;
      a_s2_q      <= a_s2_d;
      b_s1_q      <= b_s1_d;
      b_s2_q      <= b_s2_d;
      a_filt_q    <= a_filt_d;
      b_filt_q    <= b_filt_d;
      a_cnt_q     <= a_cnt_d;
      b_cnt_q     <= b_cnt_d;
      state_q     <= state_d;
      car_enter_q <= car_enter_d;
      car_exit_q  <= car_exit_d;
      seq_error_q <= seq_error_d;
      lane_busy_q <= lane_busy_d;
    end
  end

  assign car_enter = car_enter_q;
  assign count_e   = car_enter_q;
  assign car_exit  = car_exit_q;
  assign seq_error = seq_error_q;
  assign lane_busy = lane_busy_q;

endmodule

// File: tb/tb_parking_gate_decoder.sv
// Scoreboard bench for parking_gate_decoder: expected pulses are queued with their due
// cycle when sensor levels are driven and matched when the DUT pulses.
module tb_parking_gate_decoder;

  localparam int DEB = 4;
  localparam int LAT = DEB + 3;
  localparam logic [2:0] K_ENTER = 3'b001;
  localparam logic [2:0] K_EXIT  = 3'b010;
  localparam logic [2:0] K_ERR   = 3'b100;

  typedef struct {
    logic [2:0] kind;
    int         at;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic sensor_a = 1'b0;
  logic sensor_b = 1'b0;
  logic car_enter, car_exit, count_e, seq_error, lane_busy;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  parking_gate_decoder #(.DEBOUNCE_CYCLES(DEB), .DB_W(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .sensor_a (sensor_a),
    .sensor_b (sensor_b),
    .car_enter(car_enter),
    .car_exit (car_exit),
    .count_e  (count_e),
    .seq_error(seq_error),
    .lane_busy(lane_busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int obs, input int expv);
    checks++;
    if (obs != expv) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Drive a sensor pair at a falling edge and hold it; a nonzero kind queues the pulse
  // this level is expected to produce LAT cycles later.
  task automatic applyStimulus(input logic a, input logic b, input int hold, input logic [2:0] kind);
    exp_t e;
    @(negedge clock);
    sensor_a = a;
    sensor_b = b;
    if (kind != 3'b000) begin
      e.kind = kind;
      e.at   = cyc + LAT;
      exp_q.push_back(e);
    end
    repeat (hold - 1) @(negedge clock);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clock);
  endtask

  always @(negedge clock) begin
    logic [2:0] kind;
    exp_t       e;
    kind = {seq_error, car_exit, car_enter};
    if (kind != 3'b000 || count_e) begin
      checkOutput("count_e_eq_enter", int'(count_e), int'(car_enter));
      checkOutput("busy_at_pulse", int'(lane_busy), int'(seq_error));
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_pulse", int'(kind), 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("pulse_kind", int'(kind), int'(e.kind));
        checkOutput("pulse_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("reset_outputs", int'({car_enter, car_exit, count_e, seq_error, lane_busy}), 0);
    reset = 1'b0;
    settle(5);

    // Entry
    applyStimulus(1'b1, 1'b0, 10, 3'b000);
    checkOutput("t1_busy_in1", int'(lane_busy), 1);
    applyStimulus(1'b1, 1'b1, 10, 3'b000);
    applyStimulus(1'b0, 1'b1, 10, 3'b000);
    applyStimulus(1'b0, 1'b0, 10, K_ENTER);
    checkOutput("t1_drain", exp_q.size(), 0);
    checkOutput("t1_busy_idle", int'(lane_busy), 0);

    // Exit
    applyStimulus(1'b0, 1'b1, 10, 3'b000);
    applyStimulus(1'b1, 1'b1, 10, 3'b000);
    applyStimulus(1'b1, 1'b0, 10, 3'b000);
    checkOutput("t2_busy_out3", int'(lane_busy), 1);
    applyStimulus(1'b0, 1'b0, 10, K_EXIT);
    checkOutput("t2_drain", exp_q.size(), 0);

    // Bounce, then the 3-cycle and 4-cycle stability boundary
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 2, 3'b000);
      applyStimulus(1'b0, 1'b0, 2, 3'b000);
    end
    settle(10);
    checkOutput("t3_bounce_idle", int'(lane_busy), 0);
    applyStimulus(1'b1, 1'b0, 3, 3'b000);
    applyStimulus(1'b0, 1'b0, 10, 3'b000);
    checkOutput("t3_three_cycle_idle", int'(lane_busy), 0);
    applyStimulus(1'b1, 1'b0, 4, 3'b000);
    applyStimulus(1'b0, 1'b0, 4, 3'b000);
    checkOutput("t3_four_cycle_in1", int'(lane_busy), 1);
    settle(10);
    checkOutput("t3_abort_idle", int'(lane_busy), 0);
    checkOutput("t3_drain", exp_q.size(), 0);

    // Abort, then backing out and re-entering
    applyStimulus(1'b1, 1'b0, 10, 3'b000);
    applyStimulus(1'b0, 1'b0, 10, 3'b000);
    checkOutput("t4_abort_idle", int'(lane_busy), 0);
    applyStimulus(1'b1, 1'b0, 10, 3'b000);
    applyStimulus(1'b1, 1'b1, 10, 3'b000);
    applyStimulus(1'b1, 1'b0, 10, 3'b000);
    applyStimulus(1'b1, 1'b1, 10, 3'b000);
    applyStimulus(1'b0, 1'b1, 10, 3'b000);
    applyStimulus(1'b0, 1'b0, 10, K_ENTER);
    checkOutput("t4_drain", exp_q.size(), 0);

    // Illegal jump 10 -> 01, hold in ERROR, recover, then a normal entry
    applyStimulus(1'b1, 1'b0, 10, 3'b000);
    applyStimulus(1'b0, 1'b1, 10, K_ERR);
    checkOutput("t5_busy_error", int'(lane_busy), 1);
    applyStimulus(1'b0, 1'b1, 20, 3'b000);
    applyStimulus(1'b0, 1'b0, 10, 3'b000);
    checkOutput("t5_busy_idle", int'(lane_busy), 0);
    applyStimulus(1'b1, 1'b0, 10, 3'b000);
    applyStimulus(1'b1, 1'b1, 10, 3'b000);
    applyStimulus(1'b0, 1'b1, 10, 3'b000);
    applyStimulus(1'b0, 1'b0, 10, K_ENTER);
    checkOutput("t5_drain", exp_q.size(), 0);

    // Reset while in IN2; the still-blocked 11 pair is then seen from IDLE as illegal
    applyStimulus(1'b1, 1'b0, 10, 3'b000);
    applyStimulus(1'b1, 1'b1, 10, 3'b000);
    checkOutput("t6_busy_in2", int'(lane_busy), 1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("t6_reset_outputs", int'({car_enter, car_exit, count_e, seq_error, lane_busy}), 0);
    begin
      exp_t e;
      e.kind = K_ERR;
      e.at   = cyc + LAT;
      exp_q.push_back(e);
    end
    settle(10);
    applyStimulus(1'b0, 1'b1, 10, 3'b000);
    applyStimulus(1'b0, 1'b0, 10, 3'b000);
    checkOutput("t6_busy_idle", int'(lane_busy), 0);
    checkOutput("t6_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
